// File: rtl/hcsr04_pkg.sv
// rtl/hcsr04_pkg.sv - shared constants and state encoding for the HC-SR04 range filter
package hcsr04_pkg;

  // Measurement FSM state encoding
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FIRE      = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_FILTER    = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  // Default timing: 60 ms repetition and 50 ms echo timeout at 50 MHz
  localparam int CLK_HZ             = 50_000_000;
  localparam int DEF_PERIOD_CYCLES  = 3_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 2_500_000;
  localparam int DEF_AVG_LOG2       = 2;
  localparam int DEF_MAX_MM         = 4000;

  // Sensor samples are 16-bit millimetre values
  localparam int SAMPLE_W = 16;

  // Running sum must hold 2^avg_log2 full-scale samples without overflow
  function automatic int sum_width(input int avg_log2);
    return SAMPLE_W + avg_log2;
  endfunction

endpackage

// File: rtl/hcsr04_avg_ring.sv
// rtl/hcsr04_avg_ring.sv - moving-average ring buffer with running sum and first-sample preload
module hcsr04_avg_ring
  import hcsr04_pkg::*;
#(
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = sum_width(AVG_LOG2);
  localparam int PTR_W = AVG_LOG2;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    ptr_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;
  logic                primed_q;

  // Replace the oldest entry in the sum; the sum never underflows since it contains that entry
  always_comb begin
    sum_d = sum_q - SUM_W'(mem_q[ptr_q]) + SUM_W'(sample);
  end

  // Buffer, pointer and sum update; the first write fills every slot so the average starts settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      ptr_q    <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
    end else if (wr) begin
      if (!primed_q) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= sample;
        end
        sum_q    <= SUM_W'(sample) << AVG_LOG2;
        primed_q <= 1'b1;
      end else begin
        mem_q[ptr_q] <= sample;
        sum_q        <= sum_d;
      end
      ptr_q <= ptr_q + PTR_W'(1);
    end
  end

  assign avg = SAMPLE_W'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/hcsr04_range_filter.sv
// rtl/hcsr04_range_filter.sv - periodic HC-SR04 trigger, timeout guard, range check and averaged output
module hcsr04_range_filter
  import hcsr04_pkg::*;
#(
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int AVG_LOG2       = DEF_AVG_LOG2,
  parameter int MAX_MM         = DEF_MAX_MM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic                start,
  input  logic                done,
  input  logic [SAMPLE_W-1:0] distance_in,
  output logic [SAMPLE_W-1:0] distance_out,
  output logic                valid,
  output logic                out_of_range,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    per_q, per_d;
  logic [CNT_W-1:0]    to_q, to_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                done_q;
  logic                start_q;
  logic                valid_q;
  logic                oor_q, oor_d;
  logic                terr_q, terr_d;

  logic done_edge;
  logic in_range;
  logic timed_out;
  logic period_end;
  logic accept;

  assign done_edge  = done & ~done_q;
  assign in_range   = (sample_q != '0) && (sample_q <= SAMPLE_W'(MAX_MM));
  assign timed_out  = (to_q == CNT_W'(TIMEOUT_CYCLES));
  // >= keeps the schedule safe even if the measurement finished very late in the period
  assign period_end = (per_q >= CNT_W'(PERIOD_CYCLES - 1));
  assign accept     = (state_q == S_FILTER) && in_range;

  // Next-state, sample capture and completion flags
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    oor_d    = oor_q;
    terr_d   = terr_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done edge coinciding with expiry still counts as a valid echo
        if (done_edge) begin
          sample_d = distance_in;
          state_d  = S_FILTER;
        end else if (timed_out) begin
          terr_d  = 1'b1;
          oor_d   = 1'b0;
          state_d = S_HOLDOFF;
        end
      end
      S_FILTER: begin
        oor_d   = ~in_range;
        terr_d  = 1'b0;
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (period_end) state_d = enable ? S_FIRE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Both counters measure cycles since the start pulse; they restart on the way into FIRE
  always_comb begin
    per_d = (state_q == S_IDLE) ? per_q : per_q + CNT_W'(1);
    to_d  = ((state_q == S_FIRE) || (state_q == S_WAIT_DONE)) ? to_q + CNT_W'(1) : to_q;
    if (state_d == S_FIRE) begin
      per_d = '0;
      to_d  = '0;
    end
  end

  // State, counters, edge detector and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      per_q    <= '0;
      to_q     <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      oor_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      to_q     <= to_d;
      sample_q <= sample_d;
      done_q   <= done;
      start_q  <= (state_d == S_FIRE);
      valid_q  <= accept;
      oor_q    <= oor_d;
      terr_q   <= terr_d;
    end
  end

  hcsr04_avg_ring #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (accept),
    .sample (sample_q),
    .avg    (distance_out)
  );

  assign start        = start_q;
  assign valid        = valid_q;
  assign out_of_range = oor_q;
  assign timeout_err  = terr_q;

endmodule

// File: doc/hcsr04_range_filter.md
# hcsr04_range_filter

- Downstream measurement controller for `hcsr04_sensor`.
- Issues periodic `start` pulses to the sensor and captures `distance` on each `done`.
- Rejects out-of-range readings and guards against a sensor that never answers.
- Delivers a moving-average distance, with a one-cycle valid strobe, to the waveform/display logic.

## Interface
Parameters:
- `PERIOD_CYCLES`, 3_000_000: cycles between successive `start` pulses (60 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 2_500_000: maximum cycles from `start` to `done` before abort. Must be < `PERIOD_CYCLES`.
- `AVG_LOG2`, 2: log2 of averaging window depth (4 samples).
- `MAX_MM`, 4000: largest accepted distance in mm.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 1 = run periodic measurements.
- `start` out 1: one-cycle pulse to sensor `start`.
- `done` in 1: sensor `done`, level or pulse; only its rising edge is used.
- `distance_in` in 16: sensor `distance`, mm.
- `distance_out` out 16: filtered distance, mm.
- `valid` out 1: one-cycle strobe when `distance_out` updates.
- `out_of_range` out 1: last completed reading was rejected.
- `timeout_err` out 1: last measurement timed out.

## Operation
- States:
  - IDLE: go to FIRE when `enable`=1.
  - FIRE: one cycle; `start`=1; clear period and timeout counters; go to WAIT_DONE.
  - WAIT_DONE:
    - `done` rising edge → FILTER.
    - Timeout counter reaches `TIMEOUT_CYCLES` → set `timeout_err`, clear `out_of_range`, go to HOLDOFF.
  - FILTER: one cycle; evaluate the captured sample, then go to HOLDOFF.
    - Sample is 0 or > `MAX_MM`: set `out_of_range`, clear `timeout_err`, write nothing to buffer, no `valid`.
    - Otherwise: clear both flags, update average, pulse `valid`.
  - HOLDOFF: wait until the period counter reaches `PERIOD_CYCLES`-1, then go to FIRE if `enable`=1, else IDLE.
- Done edge detection: `done` registered once; edge = `done` & ~`done_q`. A `done` already high on entering WAIT_DONE is not an edge.
- `distance_in` is captured into a sample register in the same cycle the edge is detected.
- Averaging:
  - Ring buffer of 2^`AVG_LOG2` × 16-bit entries, plus a running sum of 16+`AVG_LOG2` bits.
  - Update: sum ← sum − oldest + new; write pointer wraps modulo depth.
  - `distance_out` = sum >> `AVG_LOG2`, truncating.
- First accepted sample after reset preloads every entry with that sample: sum = sample << `AVG_LOG2`, so the first output equals the sample.
- `enable` dropped mid-measurement: the current measurement completes (done or timeout) through FILTER/HOLDOFF, then the block goes to IDLE. No `start` is issued while `enable`=0.
- `done` edge in the same cycle the timeout counter expires: the done edge wins.
- Stray `done` edges outside WAIT_DONE are ignored.

## Timing
- Reset values:
  - `start`=0, `valid`=0, `distance_out`=0, `out_of_range`=0, `timeout_err`=0.
  - State IDLE; buffer, sum, pointer and preload flag all cleared.
- `enable` sampled 1 in IDLE at edge k → `start` high during cycle k+1.
- `start` pulse to next `start` pulse: exactly `PERIOD_CYCLES` cycles, independent of echo length or timeout.
- `done` rising edge sampled at edge k → FILTER at k+1 → `valid`, `distance_out` and flags registered at k+2.
- Flags are levels, updated only at measurement completion.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). The first `start` after release requires `enable`.

## Structure
- Package `hcsr04_pkg` holds:
  - state encoding localparams;
  - default timing constants (`CLK_HZ`=50_000_000, `PERIOD_CYCLES`, `TIMEOUT_CYCLES`);
  - the sum-width expression.
- Sub-module `hcsr04_avg_ring`:
  - inputs: `clk`, `rst_n`, `wr`, `sample[15:0]`;
  - output: `avg[15:0]`;
  - contains the buffer, pointer, running sum and preload logic.
- Top level holds the FSM, counters, edge detector and range check.

## Test plan
Bench parameters: `PERIOD_CYCLES`=1000, `TIMEOUT_CYCLES`=800, `AVG_LOG2`=2.
1. `enable`=1, `done` rising edge 200 cycles after `start` with `distance_in`=100 → `valid` 2 cycles after the edge, `distance_out`=100; next `start` exactly 1000 cycles after the first.
2. Accepted samples 100, 200, 300, 400 → `distance_out` sequence 100, 125, 175, 250; a fifth sample of 401 → 325 (truncated from 1301/4).
3. `distance_in`=5000 → no `valid`, `out_of_range`=1, `distance_out` unchanged; next sample 100 → `out_of_range`=0, `valid` pulses.
4. No `done` after `start` → `timeout_err`=1 at cycle 800; next `start` at cycle 1000. A `done` edge on cycle 800 exactly → sample accepted, `timeout_err`=0.
5. `enable`→0 during WAIT_DONE → current result delivered, then no further `start`; `enable`→1 → `start` after HOLDOFF/IDLE.
6. `rst_n` pulsed low in WAIT_DONE → all outputs 0 immediately; the first sample after release (e.g. 300) preloads, giving `distance_out`=300.
